// File: rtl/reg8_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg8_wr_arbiter_if
// Bundles the requester-side request/data/lock signals and the registered
// write/grant outputs of reg8_wr_arbiter.
//   req_i  [3:0]        level write request, one bit per requester
//   d_i    [4*WIDTH-1:0] write data, requester k at [WIDTH*k +: WIDTH]
//   lock_i [3:0]        hold-ownership request (only with REG8_ARB_LOCK_EN)
//   gnt_o  [3:0]        one-hot grant pulse
//   wen_o               write enable towards reg8.wen_i
//   d_o    [WIDTH-1:0]  write data towards reg8.d_i
//   gid_o  [1:0]        index of the most recent grantee
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: REG8_ARB_LOCK_EN
// ----------------------------------------------------------------------------
interface reg8_wr_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned NREQ = 4;
   localparam int unsigned IDXW = 2;

   logic [NREQ-1:0]       req_i;
   logic [NREQ*WIDTH-1:0] d_i;
`ifdef REG8_ARB_LOCK_EN
   logic [NREQ-1:0]       lock_i;
`endif
   logic [NREQ-1:0]       gnt_o;
   logic                  wen_o;
   logic [WIDTH-1:0]      d_o;
   logic [IDXW-1:0]       gid_o;

`ifdef REG8_ARB_LOCK_EN
   modport master (
      output req_i, d_i, lock_i,
      input  gnt_o, wen_o, d_o, gid_o
   );
   modport slave (
      input  req_i, d_i, lock_i,
      output gnt_o, wen_o, d_o, gid_o
   );
`else
   modport master (
      output req_i, d_i,
      input  gnt_o, wen_o, d_o, gid_o
   );
   modport slave (
      input  req_i, d_i,
      output gnt_o, wen_o, d_o, gid_o
   );
`endif

endinterface

// File: rtl/reg8_wr_arbiter.sv
// ----------------------------------------------------------------------------
// reg8_wr_arbiter
// Round-robin write arbiter sharing one reg8 holding register among four
// requesters. One winner per cycle; the winner's data and a write enable are
// registered towards reg8, and a one-cycle one-hot grant goes back.
// Ports:
//   clk_i   rising-edge clock (shared with reg8)
//   clrn_i  asynchronous active-low clear (same net as reg8.clrn_i)
//   bus     reg8_wr_arbiter_if.slave: req_i, d_i, [lock_i] in;
//           gnt_o, wen_o, d_o, gid_o out (all registered)
// Optional feature macro: REG8_ARB_LOCK_EN
//   defined   : lock_i exists; a requester winning with its lock bit set keeps
//               ownership (LOCKED state) until its lock bit drops.
//   undefined : IDLE-only FSM; every grant is a single pulse.
// ----------------------------------------------------------------------------
module reg8_wr_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                clrn_i,
   reg8_wr_arbiter_if.slave    bus
);

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDXW = 2;

   localparam logic [0:0] ST_IDLE   = 1'b0;
`ifdef REG8_ARB_LOCK_EN
   localparam logic [0:0] ST_LOCKED = 1'b1;
`endif

   logic [0:0]       state_q, state_d;
   logic [IDXW-1:0]  ptr_q,   ptr_d;
   logic [IDXW-1:0]  gid_q,   gid_d;
   logic [NREQ-1:0]  gnt_q,   gnt_d;
   logic             wen_q,   wen_d;
   logic [WIDTH-1:0] dout_q,  dout_d;

   logic [NREQ-1:0]  elig;
   logic             found;
   logic [IDXW-1:0]  win;
   logic [IDXW-1:0]  idx;

   // Eligible requesters: last grantee is masked in IDLE; only the owner in LOCKED
   always_comb begin
      elig = bus.req_i & ~gnt_q;
`ifdef REG8_ARB_LOCK_EN
      if (state_q == ST_LOCKED) begin
         elig = bus.req_i & (NREQ'(1) << gid_q);
      end
`endif
   end

   // Round-robin search starting at ptr; 2-bit index wraps naturally mod 4
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = ptr_q + IDXW'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      dout_d  = dout_q;
      gnt_d   = '0;
      wen_d   = 1'b0;

      if (found) begin
         gnt_d  = NREQ'(1) << win;
         wen_d  = 1'b1;
         dout_d = bus.d_i[WIDTH*win +: WIDTH];
         gid_d  = win;
      end

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               ptr_d = win + IDXW'(1);
`ifdef REG8_ARB_LOCK_EN
               if (bus.lock_i[win]) begin
                  state_d = ST_LOCKED;
               end
`endif
            end
         end
`ifdef REG8_ARB_LOCK_EN
         // Owner keeps the register; ptr frozen until the lock is released
         ST_LOCKED: begin
            if (!bus.lock_i[gid_q]) begin
               state_d = ST_IDLE;
               ptr_d   = gid_q + IDXW'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         gnt_q   <= '0;
         wen_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         gnt_q   <= gnt_d;
         wen_q   <= wen_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.gnt_o = gnt_q;
   assign bus.wen_o = wen_q;
   assign bus.d_o   = dout_q;
   assign bus.gid_o = gid_q;

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg8_wr_arbiter
// Directed stimulus with a write scoreboard: each stimulus step pushes the
// writes it should cause; a negedge monitor pops one entry per wen_o pulse and
// also checks that a behavioural reg8 captured the data one edge later.
// ----------------------------------------------------------------------------
module tb_reg8_wr_arbiter;

   localparam int unsigned WIDTH = 8;

   typedef struct packed {
      logic [3:0]       gnt;
      logic [WIDTH-1:0] d;
      logic [1:0]       gid;
   } exp_t;

   logic clk = 1'b0;
   logic clrn;

   reg8_wr_arbiter_if #(.WIDTH(WIDTH)) bif ();

   reg8_wr_arbiter #(.WIDTH(WIDTH)) dut (
      .clk_i  (clk),
      .clrn_i (clrn),
      .bus    (bif)
   );

   // Behavioural reg8 sharing clock and clear
   logic [WIDTH-1:0] reg_q;
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)           reg_q <= '0;
      else if (bif.wen_o)  reg_q <= bif.d_o;
   end

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   task automatic push(input logic [3:0] g, input logic [WIDTH-1:0] d, input logic [1:0] id);
      exp_t e;
      e.gnt = g;
      e.d   = d;
      e.gid = id;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every write against the scoreboard
   logic             pend = 1'b0;
   logic [WIDTH-1:0] pend_d = '0;
   exp_t             mon_e;
   always @(negedge clk) begin
      if (!clrn) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check("reg8_q", 32'(reg_q), 32'(pend_d));
            pend = 1'b0;
         end
         if (bif.wen_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write_gnt", 32'(bif.gnt_o), 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               check("gnt", 32'(bif.gnt_o), 32'(mon_e.gnt));
               check("d_o", 32'(bif.d_o),   32'(mon_e.d));
               check("gid", 32'(bif.gid_o), 32'(mon_e.gid));
               pend   = 1'b1;
               pend_d = mon_e.d;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clrn      = 1'b1;
      bif.req_i = '0;
      bif.d_i   = '0;
`ifdef REG8_ARB_LOCK_EN
      bif.lock_i = '0;
`endif
      #3 clrn = 1'b0;

      // Reset held with all requesting: outputs stay zero
      bif.req_i = 4'b1111;
      bif.d_i   = 32'h44332211;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(bif.gnt_o), 32'h0);
      check("rst_wen", 32'(bif.wen_o), 32'h0);
      check("rst_d",   32'(bif.d_o),   32'h0);
      check("rst_gid", 32'(bif.gid_o), 32'h0);
      check("rst_reg", 32'(reg_q),     32'h0);

      // Release: round robin 0,1,2,3,0 with one grant per cycle
      #2 clrn = 1'b1;
      push(4'b0001, 8'h11, 2'd0);
      push(4'b0010, 8'h22, 2'd1);
      push(4'b0100, 8'h33, 2'd2);
      push(4'b1000, 8'h44, 2'd3);
      push(4'b0001, 8'h11, 2'd0);
      repeat (5) @(posedge clk);
      #1 bif.req_i = '0;
      @(posedge clk);

      // Single write from requester 2 (ptr = 1)
      #1;
      bif.req_i = 4'b0100;
      bif.d_i   = 32'h00A50000;
      push(4'b0100, 8'hA5, 2'd2);
      @(posedge clk);
      #1 bif.req_i = '0;
      @(posedge clk);

      // Mask: requester 1 alone for 4 cycles -> writes on cycles 1 and 3
      #1;
      bif.req_i = 4'b0010;
      bif.d_i   = 32'h00005A00;
      push(4'b0010, 8'h5A, 2'd1);
      push(4'b0010, 8'h5A, 2'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("mask_wen", 32'(bif.wen_o), (i == 0 || i == 2) ? 32'h1 : 32'h0);
      end
      bif.req_i = '0;

      // Async clear while a write is on the outputs (ptr = 2)
      @(posedge clk);
      #1;
      bif.req_i = 4'b1111;
      bif.d_i   = 32'hD4C3B2A1;
      push(4'b0100, 8'hC3, 2'd2);
      @(posedge clk);
      #1 bif.req_i = '0;
      @(negedge clk);
      check("clr_pre_wen", 32'(bif.wen_o), 32'h1);
      #2 clrn = 1'b0;
      #1;
      check("clr_wen", 32'(bif.wen_o), 32'h0);
      check("clr_gnt", 32'(bif.gnt_o), 32'h0);
      check("clr_d",   32'(bif.d_o),   32'h0);
      check("clr_gid", 32'(bif.gid_o), 32'h0);
      check("clr_reg", 32'(reg_q),     32'h0);
      repeat (2) @(negedge clk);
      #2 clrn = 1'b1;

`ifdef REG8_ARB_LOCK_EN
      // Lock: requester 2 holds 4 writes while 0 waits; 0 follows the release
      @(posedge clk);
      #1;
      bif.req_i  = 4'b0100;
      bif.lock_i = 4'b0100;
      bif.d_i    = 32'h00E70015;
      push(4'b0100, 8'hE7, 2'd2);
      push(4'b0100, 8'hE7, 2'd2);
      push(4'b0100, 8'hE7, 2'd2);
      push(4'b0100, 8'hE7, 2'd2);
      push(4'b0001, 8'h15, 2'd0);
      @(posedge clk);
      #1 bif.req_i = 4'b0101;
      repeat (3) @(posedge clk);
      #1;
      bif.lock_i = '0;
      bif.req_i  = 4'b0001;
      repeat (2) @(posedge clk);
      #1 bif.req_i = '0;
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
